// File: rtl/addr8u_sched_pkg.sv
// Shared types and widths for the two-requester TMR adder scheduler.
package addr8u_sched_pkg;

    localparam int OPW  = 8;   // operand width
    localparam int SUMW = 9;   // sum width including carry

    // Scheduler states: three adder passes, a vote, then the held response.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EVAL0 = 3'd1,
        EVAL1 = 3'd2,
        EVAL2 = 3'd3,
        VOTE  = 3'd4,
        RESP  = 3'd5
    } state_t;

    // Which of the three pass registers an evaluation cycle fills.
    typedef logic [1:0] pass_idx_t;

    function automatic logic is_eval(input state_t s);
        return (s == EVAL0) || (s == EVAL1) || (s == EVAL2);
    endfunction

    function automatic pass_idx_t pass_of(input state_t s);
        case (s)
            EVAL1:   return 2'd1;
            EVAL2:   return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/tmr_vote9.sv
// 9-bit bitwise 2-of-3 majority with pairwise full-equality flags.
module tmr_vote9
    import addr8u_sched_pkg::*;
(
    input  logic [SUMW-1:0] p0_i,
    input  logic [SUMW-1:0] p1_i,
    input  logic [SUMW-1:0] p2_i,
    output logic [SUMW-1:0] maj_o,
    output logic            eq01_o,
    output logic            eq02_o,
    output logic            eq12_o
);

    // Each bit takes the value held by at least two of the three passes.
    always_comb begin
        maj_o  = (p0_i & p1_i) | (p0_i & p2_i) | (p1_i & p2_i);
        eq01_o = (p0_i == p1_i);
        eq02_o = (p0_i == p2_i);
        eq12_o = (p1_i == p2_i);
    end

endmodule

// File: rtl/addr8u_tr_sched.sv
// Round-robin scheduler for two requesters sharing one external 8-bit adder.
// Each sum is computed three times (the middle pass with swapped operands),
// majority-voted, and optionally re-evaluated when no two passes agree.
module addr8u_tr_sched
    import addr8u_sched_pkg::*;
#(
    parameter int RETRY_MAX = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [OPW-1:0]  req_a0,
    input  logic [OPW-1:0]  req_b0,
    input  logic [OPW-1:0]  req_a1,
    input  logic [OPW-1:0]  req_b1,
    output logic [OPW-1:0]  add_a,
    output logic [OPW-1:0]  add_b,
    input  logic [SUMW-1:0] add_o,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [SUMW-1:0] resp_sum,
    output logic            resp_id,
    output logic            resp_err,
    output logic            resp_fail
);

    localparam logic [1:0] RMAX = 2'(RETRY_MAX);

    state_t          state_q;
    logic            last_q;       // requester granted most recently
    logic            id_q;
    logic [OPW-1:0]  a_q, b_q;
    logic [1:0]      retry_q;
    logic [1:0]      retry_d;
    logic [SUMW-1:0] pass0_q, pass1_q, pass2_q;
    logic [OPW-1:0]  add_a_q, add_b_q;
    logic            resp_valid_q, resp_id_q, resp_err_q, resp_fail_q;
    logic [SUMW-1:0] resp_sum_q;

    logic            grant_id;
    logic            accept;
    logic [OPW-1:0]  sel_a, sel_b;
    logic [SUMW-1:0] maj;
    logic            eq01, eq02, eq12;
    logic            any_pair;
    logic            any_diff;

    tmr_vote9 u_vote (
        .p0_i   (pass0_q),
        .p1_i   (pass1_q),
        .p2_i   (pass2_q),
        .maj_o  (maj),
        .eq01_o (eq01),
        .eq02_o (eq02),
        .eq12_o (eq12)
    );

    // Grant selection: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        grant_id = ~last_q;
        case (req_valid)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            default: grant_id = ~last_q;
        endcase
        req_ready = 2'b00;
        if (!rst && state_q == IDLE && req_valid[grant_id])
            req_ready[grant_id] = 1'b1;
    end

    // Operand mux, vote summary and retry increment.
    always_comb begin
        accept   = |(req_valid & req_ready);
        sel_a    = grant_id ? req_a1 : req_a0;
        sel_b    = grant_id ? req_b1 : req_b0;
        any_pair = eq01 | eq02 | eq12;
        any_diff = (pass0_q != maj) | (pass1_q != maj) | (pass2_q != maj);
        retry_d  = retry_q + 2'd1;
    end

    // Transaction FSM with registered adder operands and response fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            id_q         <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            retry_q      <= '0;
            pass0_q      <= '0;
            pass1_q      <= '0;
            pass2_q      <= '0;
            add_a_q      <= '0;
            add_b_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_sum_q   <= '0;
            resp_id_q    <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_fail_q  <= 1'b0;
        end else begin
            if (is_eval(state_q)) begin
                case (pass_of(state_q))
                    2'd1:    pass1_q <= add_o;
                    2'd2:    pass2_q <= add_o;
                    default: pass0_q <= add_o;
                endcase
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= sel_a;
                        b_q     <= sel_b;
                        id_q    <= grant_id;
                        last_q  <= grant_id;
                        retry_q <= '0;
                        add_a_q <= sel_a;
                        add_b_q <= sel_b;
                        state_q <= EVAL0;
                    end
                end
                EVAL0: begin
                    add_a_q <= b_q;
                    add_b_q <= a_q;
                    state_q <= EVAL1;
                end
                EVAL1: begin
                    add_a_q <= a_q;
                    add_b_q <= b_q;
                    state_q <= EVAL2;
                end
                EVAL2: begin
                    add_a_q <= '0;
                    add_b_q <= '0;
                    state_q <= VOTE;
                end
                VOTE: begin
                    if (any_pair) begin
                        resp_sum_q   <= maj;
                        resp_err_q   <= any_diff;
                        resp_fail_q  <= 1'b0;
                        resp_id_q    <= id_q;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else if (retry_q < RMAX) begin
                        retry_q <= retry_d;
                        add_a_q <= a_q;
                        add_b_q <= b_q;
                        state_q <= EVAL0;
                    end else begin
                        resp_sum_q   <= maj;
                        resp_err_q   <= 1'b1;
                        resp_fail_q  <= 1'b1;
                        resp_id_q    <= id_q;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_sum_q   <= '0;
                        resp_id_q    <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_fail_q  <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign add_a      = add_a_q;
    assign add_b      = add_b_q;
    assign resp_valid = resp_valid_q;
    assign resp_sum   = resp_sum_q;
    assign resp_id    = resp_id_q;
    assign resp_err   = resp_err_q;
    assign resp_fail  = resp_fail_q;

endmodule

// File: tb/tb_addr8u_tr_sched.sv
// Scoreboard bench for addr8u_tr_sched with a behavioural adder that can inject faults.
module tb_addr8u_tr_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_valid = 2'b11;
    logic [1:0] req_ready;
    logic [7:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [7:0] add_a, add_b;
    logic [8:0] add_o;
    logic       resp_valid;
    logic       resp_ready = 1'b1;
    logic [8:0] resp_sum;
    logic       resp_id, resp_err, resp_fail;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;
    int mode = 0;   // 0 ideal adder, 1 flip bit 3 on the swapped pass, 2 three distinct results
    int phase = 0;  // cycles since accept: 1..3 first passes, 5..7 retry passes

    typedef struct packed {
        logic [8:0] sum;
        logic       id;
        logic       err;
        logic       fail;
    } exp_t;
    exp_t sbq[$];

    addr8u_tr_sched #(.RETRY_MAX(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .add_a(add_a), .add_b(add_b), .add_o(add_o),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_sum(resp_sum), .resp_id(resp_id),
        .resp_err(resp_err), .resp_fail(resp_fail)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [8:0] maj3(input logic [8:0] x, input logic [8:0] y, input logic [8:0] z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Pass tracker for the fault-injecting adder
    always @(posedge clk or posedge rst) begin
        if (rst) phase <= 0;
        else if ((req_valid & req_ready) != 2'b00) phase <= 1;
        else if (phase != 0) phase <= phase + 1;
    end

    // Behavioural shared adder
    always_comb begin
        logic [8:0] s;
        s = {1'b0, add_a} + {1'b0, add_b};
        add_o = s;
        if (mode == 1 && phase == 2) add_o = s ^ 9'h008;
        if (mode == 2) begin
            case ((phase - 1) % 4)
                0:       add_o = s ^ 9'h0F0;
                1:       add_o = s ^ 9'h00F;
                default: add_o = s ^ 9'h1FF;
            endcase
        end
    end

    // Push the expected response whenever a request is accepted
    always @(negedge clk) begin
        exp_t e;
        logic [7:0] a, b;
        logic [8:0] s;
        if (!rst && (req_valid & req_ready) != 2'b00) begin
            e.id = req_ready[1];
            a = e.id ? req_a1 : req_a0;
            b = e.id ? req_b1 : req_b0;
            s = {1'b0, a} + {1'b0, b};
            e.sum = s; e.err = 1'b0; e.fail = 1'b0;
            if (mode == 1) e.err = 1'b1;
            if (mode == 2) begin
                e.sum = maj3(s ^ 9'h0F0, s ^ 9'h00F, s ^ 9'h1FF);
                e.err = 1'b1; e.fail = 1'b1;
            end
            sbq.push_back(e);
        end
    end

    // Present a request and hold it until accepted; returns just after the accepting edge
    task automatic issue(input logic [1:0] v, input logic [7:0] x0, input logic [7:0] y0,
                         input logic [7:0] x1, input logic [7:0] y1, output bit ok, output int t);
        req_a0 = x0; req_b0 = y0; req_a1 = x1; req_b1 = y1; req_valid = v;
        ok = 0; t = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if ((req_valid & req_ready) != 2'b00) begin ok = 1; t = cyc; end
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
    endtask

    // Wait (bounded) for resp_valid; returns at the sampling edge where it is seen
    task automatic wait_resp(input int lim, output bit ok);
        ok = 0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk);
            if (resp_valid) ok = 1;
        end
    endtask

    task automatic test_reset;
        #2;
        vecs++;
        if (req_ready !== 2'b00 || resp_valid !== 1'b0 || resp_sum !== 9'h0 || resp_id !== 1'b0 ||
            resp_err !== 1'b0 || resp_fail !== 1'b0 || add_a !== 8'h0 || add_b !== 8'h0) begin
            errs++;
            $display("FAIL reset_outputs: rdy=%b vld=%b sum=%h id=%b err=%b fail=%b a=%h b=%h, need all 0",
                     req_ready, resp_valid, resp_sum, resp_id, resp_err, resp_fail, add_a, add_b);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        vecs++;
        if (req_ready !== 2'b01) begin
            errs++; $display("FAIL reset_rr_ptr: req_ready=%b need 01", req_ready);
        end
        #1 req_valid = 2'b00;
        sbq.delete();
    endtask

    task automatic test_rr_back_to_back;
        bit ok; int t; exp_t e;
        @(posedge clk); #1;
        mode = 0; resp_ready = 1'b1;
        req_a0 = 8'h10; req_b0 = 8'h20; req_a1 = 8'hFF; req_b1 = 8'hFF; req_valid = 2'b11;
        ok = 0; t = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin ok = 1; t = cyc; end
        end
        vecs++;
        if (req_ready !== 2'b01) begin errs++; $display("FAIL rr_first_grant: req_ready=%b need 01", req_ready); end
        wait_resp(20, ok);
        vecs++;
        if (!ok || cyc - t != 5) begin errs++; $display("FAIL rr_lat0: seen=%0d lat=%0d need 5", ok, cyc - t); end
        vecs++;
        if (sbq.size() == 0) begin errs++; $display("FAIL rr_resp0: no expectation queued"); end
        else begin
            e = sbq.pop_front();
            if (resp_sum !== e.sum || resp_id !== e.id || resp_err !== e.err || resp_fail !== e.fail) begin
                errs++; $display("FAIL rr_resp0: got sum=%h id=%b err=%b fail=%b need %h %b %b %b",
                                 resp_sum, resp_id, resp_err, resp_fail, e.sum, e.id, e.err, e.fail);
            end
        end
        @(negedge clk);
        vecs++;
        if (req_ready !== 2'b10) begin errs++; $display("FAIL rr_second_grant: req_ready=%b need 10", req_ready); end
        t = cyc;
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_resp(20, ok);
        vecs++;
        if (!ok || cyc - t != 5) begin errs++; $display("FAIL rr_lat1: seen=%0d lat=%0d need 5", ok, cyc - t); end
        vecs++;
        if (sbq.size() == 0) begin errs++; $display("FAIL rr_resp1: no expectation queued"); end
        else begin
            e = sbq.pop_front();
            if (resp_sum !== e.sum || resp_id !== e.id || resp_err !== e.err || resp_fail !== e.fail ||
                resp_sum !== 9'h1FE) begin
                errs++; $display("FAIL rr_resp1: got sum=%h id=%b err=%b fail=%b need %h %b %b %b",
                                 resp_sum, resp_id, resp_err, resp_fail, e.sum, e.id, e.err, e.fail);
            end
        end
    endtask

    task automatic test_basic;
        bit ok; int t; exp_t e;
        logic [7:0] ea [4];
        logic [7:0] eb [4];
        ea = '{8'h3C, 8'h15, 8'h3C, 8'h00};
        eb = '{8'h15, 8'h3C, 8'h15, 8'h00};
        @(posedge clk); #1;
        mode = 0; resp_ready = 1'b1;
        issue(2'b01, 8'h3C, 8'h15, 8'h00, 8'h00, ok, t);
        req_a0 = 8'hAA; req_b0 = 8'h55;   // late operand change must be ignored
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vecs++;
            if (add_a !== ea[k] || add_b !== eb[k]) begin
                errs++; $display("FAIL basic_operands[%0d]: add_a=%h add_b=%h need %h %h", k, add_a, add_b, ea[k], eb[k]);
            end
        end
        wait_resp(10, ok);
        vecs++;
        if (!ok || cyc - t != 5) begin errs++; $display("FAIL basic_latency: seen=%0d lat=%0d need 5", ok, cyc - t); end
        vecs++;
        if (sbq.size() == 0) begin errs++; $display("FAIL basic_resp: no expectation queued"); end
        else begin
            e = sbq.pop_front();
            if (resp_sum !== e.sum || resp_id !== e.id || resp_err !== e.err || resp_fail !== e.fail ||
                resp_sum !== 9'h051) begin
                errs++; $display("FAIL basic_resp: got sum=%h id=%b err=%b fail=%b need %h %b %b %b",
                                 resp_sum, resp_id, resp_err, resp_fail, e.sum, e.id, e.err, e.fail);
            end
        end
    endtask

    task automatic test_flip;
        bit ok; int t; exp_t e;
        @(posedge clk); #1;
        mode = 1; resp_ready = 1'b1;
        issue(2'b10, 8'h00, 8'h00, 8'h80, 8'h7F, ok, t);
        wait_resp(20, ok);
        vecs++;
        if (!ok || cyc - t != 5) begin errs++; $display("FAIL flip_latency: seen=%0d lat=%0d need 5", ok, cyc - t); end
        vecs++;
        if (sbq.size() == 0) begin errs++; $display("FAIL flip_resp: no expectation queued"); end
        else begin
            e = sbq.pop_front();
            if (resp_sum !== e.sum || resp_id !== e.id || resp_err !== e.err || resp_fail !== e.fail) begin
                errs++; $display("FAIL flip_resp: got sum=%h id=%b err=%b fail=%b need %h %b %b %b",
                                 resp_sum, resp_id, resp_err, resp_fail, e.sum, e.id, e.err, e.fail);
            end
        end
        mode = 0;
    endtask

    task automatic test_distinct;
        bit ok; int t; exp_t e;
        @(posedge clk); #1;
        mode = 2; resp_ready = 1'b1;
        issue(2'b01, 8'h12, 8'h34, 8'h00, 8'h00, ok, t);
        wait_resp(30, ok);
        vecs++;
        if (!ok || cyc - t != 9) begin errs++; $display("FAIL distinct_latency: seen=%0d lat=%0d need 9", ok, cyc - t); end
        vecs++;
        if (sbq.size() == 0) begin errs++; $display("FAIL distinct_resp: no expectation queued"); end
        else begin
            e = sbq.pop_front();
            if (resp_sum !== e.sum || resp_id !== e.id || resp_err !== e.err || resp_fail !== e.fail ||
                resp_sum !== 9'h0B9) begin
                errs++; $display("FAIL distinct_resp: got sum=%h id=%b err=%b fail=%b need %h %b %b %b",
                                 resp_sum, resp_id, resp_err, resp_fail, e.sum, e.id, e.err, e.fail);
            end
        end
        mode = 0;
    endtask

    task automatic test_backpressure;
        bit ok; int t; exp_t e;
        logic [8:0] hs; logic hi, he, hf;
        bit bad;
        @(posedge clk); #1;
        mode = 0; resp_ready = 1'b0;
        issue(2'b01, 8'h01, 8'hFE, 8'h00, 8'h00, ok, t);
        wait_resp(20, ok);
        vecs++;
        if (!ok) begin errs++; $display("FAIL bp_resp_seen: resp_valid=%b need 1", resp_valid); end
        hs = resp_sum; hi = resp_id; he = resp_err; hf = resp_fail;
        #1 req_valid = 2'b11;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_sum !== hs || resp_id !== hi || resp_err !== he ||
                resp_fail !== hf || req_ready !== 2'b00) bad = 1;
        end
        vecs++;
        if (bad) begin errs++; $display("FAIL bp_hold: vld=%b sum=%h rdy=%b need 1 %h 00", resp_valid, resp_sum, req_ready, hs); end
        #1 req_valid = 2'b00; resp_ready = 1'b1;
        @(negedge clk);
        vecs++;
        if (resp_valid !== 1'b0) begin errs++; $display("FAIL bp_release: resp_valid=%b need 0", resp_valid); end
        vecs++;
        if (sbq.size() == 0) begin errs++; $display("FAIL bp_resp: no expectation queued"); end
        else begin
            e = sbq.pop_front();
            if (hs !== e.sum || hi !== e.id || he !== e.err || hf !== e.fail) begin
                errs++; $display("FAIL bp_resp: got sum=%h id=%b err=%b fail=%b need %h %b %b %b",
                                 hs, hi, he, hf, e.sum, e.id, e.err, e.fail);
            end
        end
    endtask

    task automatic test_reset_mid;
        bit ok; int t; bit bad;
        @(posedge clk); #1;
        mode = 0; resp_ready = 1'b1;
        issue(2'b01, 8'h44, 8'h22, 8'h00, 8'h00, ok, t);
        @(posedge clk); #1;            // now in the swapped pass
        rst = 1'b1; req_valid = 2'b11;
        #2;
        vecs++;
        if (req_ready !== 2'b00 || resp_valid !== 1'b0 || add_a !== 8'h00 || add_b !== 8'h00) begin
            errs++; $display("FAIL midrst_hold: rdy=%b vld=%b a=%h b=%h need 00 0 00 00", req_ready, resp_valid, add_a, add_b);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        vecs++;
        if (req_ready !== 2'b01) begin errs++; $display("FAIL midrst_idle: req_ready=%b need 01", req_ready); end
        #1 req_valid = 2'b00;
        sbq.delete();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) bad = 1;
        end
        vecs++;
        if (bad) begin errs++; $display("FAIL midrst_no_resp: resp_valid seen high, need 0"); end
    endtask

    initial begin
        test_reset();
        test_rr_back_to_back();
        test_basic();
        test_flip();
        test_distinct();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
